// File: rtl/select_extreme_pipelined_pkg.sv
// Shared constants and helpers for the pipelined extreme-value selector.
package select_extreme_pipelined_pkg;

  localparam logic SELECT_MODE_MAX = 1'b0;
  localparam logic SELECT_MODE_MIN = 1'b1;

  localparam int DEFAULT_WAY_WIDTH = 4;
  localparam int DEFAULT_NUM_WAY   = 16;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/select_extreme_node.sv
// Two-input compare cell of the reduction tree; ties go to the lower way.
module select_extreme_node
  import select_extreme_pipelined_pkg::*;
#(
  parameter int W  = DEFAULT_WAY_WIDTH,
  parameter int IW = 4
) (
  input  logic [W-1:0]  lo_val_in,
  input  logic [IW-1:0] lo_idx_in,
  input  logic          lo_elig_in,
  input  logic [W-1:0]  hi_val_in,
  input  logic [IW-1:0] hi_idx_in,
  input  logic          hi_elig_in,
  input  logic          mode_in,
  output logic [W-1:0]  val_out,
  output logic [IW-1:0] idx_out,
  output logic          elig_out
);

  logic hi_better;

  always_comb begin
    hi_better = 1'b0;
    val_out   = '0;
    idx_out   = '0;
    elig_out  = lo_elig_in | hi_elig_in;
    if (mode_in == SELECT_MODE_MIN) begin
      hi_better = hi_val_in < lo_val_in;
    end else begin
      hi_better = hi_val_in > lo_val_in;
    end
    unique case (1'b1)
      lo_elig_in && hi_elig_in: begin
        val_out = hi_better ? hi_val_in : lo_val_in;
        idx_out = hi_better ? hi_idx_in : lo_idx_in;
      end
      hi_elig_in && !lo_elig_in: begin
        val_out = hi_val_in;
        idx_out = hi_idx_in;
      end
      lo_elig_in && !hi_elig_in: begin
        val_out = lo_val_in;
        idx_out = lo_idx_in;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/select_extreme_pipelined.sv
// Pipelined max/min selector: heap-ordered reduction tree, one register
// stage per tree level, global stall on downstream backpressure.
module select_extreme_pipelined
  import select_extreme_pipelined_pkg::*;
#(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = DEFAULT_WAY_WIDTH,
  parameter int NUM_WAY                  = DEFAULT_NUM_WAY,
  parameter int NUM_WAY_INDEX_WIDTH      = clog2_f(NUM_WAY)
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_in,
  input  logic [NUM_WAY-1:0]                    condition_in,
  input  logic                                  mode_in,
  input  logic                                  valid_in,
  output logic                                  ready_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]   select_out,
  output logic [NUM_WAY_INDEX_WIDTH-1:0]        index_out,
  output logic                                  hit_out,
  output logic                                  valid_out,
  input  logic                                  ready_in
);

  localparam int W  = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int L  = NUM_WAY_INDEX_WIDTH;
  localparam int NN = NUM_WAY - 1;

  logic         advance;
  logic [L-1:0] vld_q, vld_d;
  logic [L-1:0] mode_q, mode_d;
  logic [L-1:0] mode_s;

  logic [W-1:0] val_q  [NN];
  logic [W-1:0] val_d  [NN];
  logic [L-1:0] idx_q  [NN];
  logic [L-1:0] idx_d  [NN];
  logic         elig_q [NN];
  logic         elig_d [NN];

  logic [W-1:0] leaf_val [NUM_WAY];

  assign advance   = !vld_q[L-1] || ready_in;
  assign ready_out = advance;

  // mode_s[k] is the mode of the request currently at stage k (0 = input)
  assign mode_s = (mode_q << 1) | L'(mode_in);

  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    if (advance) begin
      vld_d  = (vld_q << 1) | L'(valid_in);
      mode_d = mode_s;
    end
  end

  for (genvar i = 0; i < NUM_WAY; i++) begin : g_leaf
    assign leaf_val[i] = condition_in[i] ?
                         way_flatted_in[i*W +: W] : '0;
  end

  // Node n has children 2n+1 (lower ways) and 2n+2; leaves follow node NN-1
  for (genvar n = 0; n < NN; n++) begin : g_node
    localparam int D  = clog2_f(n + 2) - 1;
    localparam int LC = 2 * n + 1;
    localparam int HC = 2 * n + 2;

    logic [W-1:0] lv, hv;
    logic [L-1:0] li, hi;
    logic         le, he;

    if (LC >= NN) begin : g_from_leaf
      assign lv = leaf_val[LC-NN];
      assign li = L'(LC - NN);
      assign le = condition_in[LC-NN];
      assign hv = leaf_val[HC-NN];
      assign hi = L'(HC - NN);
      assign he = condition_in[HC-NN];
    end else begin : g_from_reg
      assign lv = val_q[LC];
      assign li = idx_q[LC];
      assign le = elig_q[LC];
      assign hv = val_q[HC];
      assign hi = idx_q[HC];
      assign he = elig_q[HC];
    end

    select_extreme_node #(
      .W (W),
      .IW(L)
    ) u_node (
      .lo_val_in (lv),
      .lo_idx_in (li),
      .lo_elig_in(le),
      .hi_val_in (hv),
      .hi_idx_in (hi),
      .hi_elig_in(he),
      .mode_in   (mode_s[L-1-D]),
      .val_out   (val_d[n]),
      .idx_out   (idx_d[n]),
      .elig_out  (elig_d[n])
    );
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      vld_q  <= '0;
      mode_q <= '0;
      for (int n = 0; n < NN; n++) begin
        val_q[n]  <= '0;
        idx_q[n]  <= '0;
        elig_q[n] <= 1'b0;
      end
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      if (advance) begin
        for (int n = 0; n < NN; n++) begin
          val_q[n]  <= val_d[n];
          idx_q[n]  <= idx_d[n];
          elig_q[n] <= elig_d[n];
        end
      end
    end
  end

  assign select_out = val_q[0];
  assign index_out  = idx_q[0];
  assign hit_out    = elig_q[0];
  assign valid_out  = vld_q[L-1];

endmodule
